// File: rtl/float_pkg.sv
// Shared FP64 definitions: field widths, saturation values, FSM states and
// operand classes used by the float conversion stages.
package float_pkg;

   localparam int EXP_W  = 11;
   localparam int MANT_W = 52;
   localparam int BIAS   = 1023;

   localparam logic [63:0] SAT_POS = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] SAT_NEG = 64'h8000_0000_0000_0000;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      SHIFT,
      FINISH,
      HOLD
   } state_t;

   typedef enum logic [2:0] {
      ZERO,
      DENORM,
      NORMAL,
      INF,
      NAN
   } fp_class_t;

endpackage

// File: rtl/fp64_classify.sv
// Combinational FP64 field decoder: class, sign, unbiased exponent and
// significand with the hidden bit restored for normal operands.
module fp64_classify
   import float_pkg::*;
(
   input  logic [63:0]            operand,
   output fp_class_t              cls,
   output logic                   sign,
   output logic signed [EXP_W:0]  exp_unb,
   output logic [MANT_W:0]        sig
);

   logic [EXP_W-1:0]  exp_field;
   logic [MANT_W-1:0] mant;

   // Split the operand into fields and classify it.
   // NOTE: every always_comb output gets a value on every path (defaults
   // first) so no latch can be inferred.
   always_comb begin
      exp_field = operand[62:52];
      mant      = operand[51:0];
      sign      = operand[63];
      exp_unb   = $signed({1'b0, exp_field}) - $signed((EXP_W+1)'(BIAS));
      sig       = {exp_field != '0, mant};
      cls       = NORMAL;
      if (exp_field == '1) begin
         cls = (mant != '0) ? NAN : INF;
      end else if (exp_field == '0) begin
         cls = (mant != '0) ? DENORM : ZERO;
      end
   end

endmodule

// File: rtl/float2int64_seq.sv
// Multi-cycle FP64 -> signed 64-bit integer converter with an iterative
// alignment shifter. Truncates toward zero by default; defining
// FLOAT2INT_RNE_EN builds round-to-nearest-even instead.
module float2int64_seq
   import float_pkg::*;
#(
   parameter int SHIFT_STEP = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        out_invalid,
   output logic        out_overflow,
   output logic        out_inexact
);

   state_t             state;
   logic [63:0]        op_q;
   logic [63:0]        acc;
   logic [6:0]         remaining;
   logic               shift_left;
   logic               sticky;
`ifdef FLOAT2INT_RNE_EN
   logic               guard;
   logic               guard_next;
   logic               below_any;
   logic               round_up;
`endif

   fp_class_t          cls;
   logic               sign;
   logic signed [EXP_W:0] exp_unb;
   logic [MANT_W:0]    sig;

   logic               in_range;
   logic [6:0]         shift_amt;
   logic [63:0]        spec_data;
   logic               spec_invalid, spec_overflow, spec_inexact;
   logic [6:0]         step;
   logic [63:0]        low_mask;
   logic [63:0]        shifted;
   logic               sticky_next;
   logic [63:0]        mag;
   logic [63:0]        fin_data;
   logic               fin_overflow, fin_inexact;

   fp64_classify u_classify (
      .operand (op_q),
      .cls     (cls),
      .sign    (sign),
      .exp_unb (exp_unb),
      .sig     (sig)
   );

   assign in_ready = (state == IDLE) || (state == HOLD && out_ready);

   // Decode-stage results: special-case outputs and the alignment distance.
   always_comb begin
      in_range      = (cls == NORMAL) && (exp_unb >= 0) && (exp_unb < 63);
      shift_amt     = (exp_unb >= 52) ? 7'(exp_unb - 12'sd52) : 7'(12'sd52 - exp_unb);
      spec_data     = '0;
      spec_invalid  = 1'b0;
      spec_overflow = 1'b0;
      spec_inexact  = 1'b0;
      case (cls)
         NAN:    spec_invalid = 1'b1;
         INF: begin
            spec_data     = sign ? SAT_NEG : SAT_POS;
            spec_overflow = 1'b1;
         end
         DENORM: spec_inexact = 1'b1;
         NORMAL: begin
            if (exp_unb < 0) begin
               spec_inexact = 1'b1;
            end else if (sign && exp_unb == 63 && sig[MANT_W-1:0] == '0) begin
               // Exactly -2^63 is representable.
               spec_data = SAT_NEG;
            end else begin
               spec_data     = sign ? SAT_NEG : SAT_POS;
               spec_overflow = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // One shifter step plus the bits it discards, and the final rounding/negate.
   always_comb begin
      step     = (remaining > 7'(SHIFT_STEP)) ? 7'(SHIFT_STEP) : remaining;
      low_mask = ~({64{1'b1}} << step);
      shifted  = shift_left ? (acc << step) : (acc >> step);
`ifdef FLOAT2INT_RNE_EN
      // Guard is the last bit shifted out; everything below it is sticky.
      guard_next   = |(acc & (64'd1 << (step - 7'd1)));
      below_any    = |(acc & low_mask & ~(64'd1 << (step - 7'd1)));
      sticky_next  = sticky | guard | below_any;
      round_up     = guard & (sticky | acc[0]);
      mag          = acc + 64'(round_up);
      fin_inexact  = guard | sticky;
      fin_overflow = mag[63] & ~sign;
`else
      sticky_next  = sticky | (|(acc & low_mask));
      mag          = acc;
      fin_inexact  = sticky;
      fin_overflow = 1'b0;
`endif
      fin_data = fin_overflow ? SAT_POS : (sign ? (~mag + 64'd1) : mag);
   end

   // Conversion FSM with registered result and flags.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the datapath registers are reset as well, so an aborted
         // conversion leaves no residue in the accumulator or sticky state.
         state        <= IDLE;
         op_q         <= '0;
         acc          <= '0;
         remaining    <= '0;
         shift_left   <= 1'b0;
         sticky       <= 1'b0;
`ifdef FLOAT2INT_RNE_EN
         guard        <= 1'b0;
`endif
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_invalid  <= 1'b0;
         out_overflow <= 1'b0;
         out_inexact  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q  <= in_data;
                  state <= DECODE;
               end
            end
            DECODE: begin
               sticky <= 1'b0;
`ifdef FLOAT2INT_RNE_EN
               guard  <= 1'b0;
`endif
               if (in_range) begin
                  acc        <= {11'd0, sig};
                  shift_left <= (exp_unb >= 52);
                  remaining  <= shift_amt;
                  state      <= (shift_amt == '0) ? FINISH : SHIFT;
               end else begin
                  out_data     <= spec_data;
                  out_invalid  <= spec_invalid;
                  out_overflow <= spec_overflow;
                  out_inexact  <= spec_inexact;
                  out_valid    <= 1'b1;
                  state        <= HOLD;
               end
            end
            SHIFT: begin
               acc       <= shifted;
               remaining <= remaining - step;
               if (!shift_left) begin
                  sticky <= sticky_next;
`ifdef FLOAT2INT_RNE_EN
                  guard  <= guard_next;
`endif
               end
               if (remaining == step) state <= FINISH;
            end
            FINISH: begin
               out_data     <= fin_data;
               out_invalid  <= 1'b0;
               out_overflow <= fin_overflow;
               out_inexact  <= fin_inexact;
               out_valid    <= 1'b1;
               state        <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     op_q  <= in_data;
                     state <= DECODE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
